// File: rtl/laby8_pkg.sv
// Shared constants and helpers for the laby8 switch-selectable square-wave generator.
package laby8_pkg;

    localparam int SEL_W = 2;

    localparam int HALF0_DEF = 25_000_000;
    localparam int HALF1_DEF = 12_500_000;
    localparam int HALF2_DEF = 6_250_000;
    localparam int HALF3_DEF = 3_125_000;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/laby8_if.sv
// Board-side signals of laby8: asynchronous switch select in, square wave out.
interface laby8_if;
    import laby8_pkg::*;

    sel_t SW;
    logic out;

    modport master (output SW, input out);
    modport slave  (input SW, output out);

endinterface

// File: rtl/laby8_sync2.sv
// Two-flop synchroniser for asynchronous inputs, reset to zero.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage1_q;
    logic [W-1:0] stage2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/laby8.sv
// Square-wave generator: divides clk by 2*HALF[sel], restarting the half-period
// cleanly whenever the synchronised switch setting changes.
module laby8
    import laby8_pkg::*;
#(
    parameter int HALF0 = HALF0_DEF,
    parameter int HALF1 = HALF1_DEF,
    parameter int HALF2 = HALF2_DEF,
    parameter int HALF3 = HALF3_DEF
) (
    input  logic     clk,
    input  logic     rst,
    laby8_if.slave   bus
);

    localparam int CW = $clog2(max4(HALF0, HALF1, HALF2, HALF3));

    sel_t          sw_s;
    sel_t          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_m1;
    logic          out_q, out_d;

    sync2 #(.W(SEL_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.SW),
        .q_o (sw_s)
    );

    always_comb begin
        half_m1 = CW'(HALF0 - 1);
        case (sel_q)
            2'd0: half_m1 = CW'(HALF0 - 1);
            2'd1: half_m1 = CW'(HALF1 - 1);
            2'd2: half_m1 = CW'(HALF2 - 1);
            2'd3: half_m1 = CW'(HALF3 - 1);
            default: half_m1 = CW'(HALF0 - 1);
        endcase
    end

    // A selection change wins over terminal count so the new setting always
    // starts with a full half-period and out never emits a runt pulse.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (sw_s != sel_q) begin
            sel_d = sw_s;
            cnt_d = '0;
        end else if (cnt_q == half_m1) begin
            cnt_d = '0;
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_laby8.sv
// Self-checking bench for laby8: edge-indexed behavioural model plus directed timing checks.
module tb_laby8;
    import laby8_pkg::*;

    localparam int H0 = 4;
    localparam int H1 = 8;
    localparam int H2 = 16;
    localparam int H3 = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    laby8_if bus ();

    always #5 clk = ~clk;

    laby8 #(.HALF0(H0), .HALF1(H1), .HALF2(H2), .HALF3(H3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic int half_of(input logic [1:0] m);
        case (m)
            2'd0: return H0;
            2'd1: return H1;
            2'd2: return H2;
            default: return H3;
        endcase
    endfunction

    // Model: SW value seen at each edge; the setting in force at edge n is the
    // one sampled at edge n-2, a change restarts the half-period, and a toggle
    // is due at an absolute edge number.
    logic [1:0] samples[$];
    logic [1:0] m_mode   = 2'd0;
    logic       m_level  = 1'b0;
    int         m_edge   = 0;
    int         m_next_t = H0;

    always @(posedge clk or posedge rst) begin
        logic [1:0] seen;
        if (rst) begin
            samples.delete();
            m_mode   = 2'd0;
            m_level  = 1'b0;
            m_edge   = 0;
            m_next_t = H0;
        end else begin
            m_edge = m_edge + 1;
            seen = (samples.size() >= 2) ? samples[samples.size()-2] : 2'd0;
            samples.push_back(bus.SW);
            if (seen != m_mode) begin
                m_mode   = seen;
                m_next_t = m_edge + half_of(seen);
            end else if (m_edge == m_next_t) begin
                m_level  = ~m_level;
                m_next_t = m_edge + half_of(m_mode);
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.out !== m_level) begin
            errors++;
            $display("FAIL model_out t=%0t: got %b expected %b (sw=%b)", $time, bus.out, m_level, bus.SW);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic wait_level(input logic v);
        for (int i = 0; i < 200; i++) begin
            if (bus.out === v) return;
            @(posedge clk);
            #1;
        end
        chk("wait_out_timeout", 0, 1);
    endtask

    task automatic count_edges_to_change(input int maxc, output int n);
        logic prev;
        prev = bus.out;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if (bus.out !== prev) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic measure_period(input string name, input longint exp_ns);
        longint t0, t1, t2;
        wait_level(1'b0);
        wait_level(1'b1);
        t0 = $time;
        wait_level(1'b0);
        t1 = $time;
        wait_level(1'b1);
        t2 = $time;
        chk({name, "_high_ns"}, t1 - t0, exp_ns / 2);
        chk({name, "_period_ns"}, t2 - t0, exp_ns);
    endtask

    initial begin
        int   n;
        int   changes;
        logic o2;
        logic start_out;

        bus.SW = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out", bus.out, 0);
        chk("reset_sel", dut.sel_q, 0);
        chk("reset_cnt", dut.cnt_q, 0);
        rst = 1'b0;

        count_edges_to_change(20, n);
        chk("first_rise_edge", n, 4);
        chk("first_rise_level", bus.out, 1);
        measure_period("sw00", 80);

        // Switch to 11 during steady 00 operation.
        @(negedge clk);
        bus.SW = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        o2 = bus.out;
        @(posedge clk); #1;
        chk("restart_cnt", dut.cnt_q, 0);
        chk("restart_out_hold", bus.out, o2);
        chk("restart_sel", dut.sel_q, 3);
        measure_period("sw11", 640);

        @(negedge clk);
        bus.SW = 2'b01;
        measure_period("sw01", 160);
        @(negedge clk);
        bus.SW = 2'b10;
        measure_period("sw10", 320);

        // Asynchronous reset mid half-period while out is high.
        wait_level(1'b1);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_out", bus.out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("sel_after_reset", dut.sel_q, 0);
        count_edges_to_change(40, n);
        chk("rise_after_reset_restart", n + 1, 3 + H2);

        // Sub-cycle glitch placed between edges.
        repeat (5) @(posedge clk);
        #3;
        bus.SW = 2'b01;
        #4;
        bus.SW = 2'b10;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_sel", dut.sel_q, 2);

        // Rapid toggling 00/01 keeps restarting the counter.
        count_edges_to_change(40, n);
        start_out = bus.out;
        changes = 0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            bus.SW = (k % 2 == 1) ? 2'b01 : 2'b00;
            if (bus.out !== start_out) changes++;
            @(negedge clk);
            if (bus.out !== start_out) changes++;
        end
        chk("toggling_no_out_change", changes, 0);
        @(negedge clk);
        bus.SW = 2'b01;
        count_edges_to_change(40, n);
        chk("settle_first_toggle_edge", n, 3 + H1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
